// File: rtl/sync_fifo_buf_if.sv
// Producer/consumer bundle for sync_fifo_buf: write and read handshakes plus occupancy and error status.
interface sync_fifo_buf_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              wr;
  logic [DWIDTH-1:0] wr_data;
  logic              rd;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, wr_data, rd,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, wr_data, rd,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO of any depth >= 2 with registered read data, occupancy count and threshold flags.
// Optional sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_buf #(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic           clk,
  input  logic           reset,
  sync_fifo_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  // Wrap by explicit compare so non-power-of-2 depths index only valid slots.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    logic [AW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {AW{1'b0}};
    end else begin
      nxt = ptr + AW'(1'b1);
    end
    return nxt;
  endfunction

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]     w_ptr_r;
  logic [AW-1:0]     r_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic              full_r;
  logic              empty_r;
  logic              almost_full_r;
  logic              almost_empty_r;
  logic [DWIDTH-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              wr_acc_s;
  logic              rd_acc_s;

  // A read frees a slot even when full; an empty FIFO never falls through.
  assign wr_acc_s = bus.wr & (~full_r | bus.rd);
  assign rd_acc_s = bus.rd & ~empty_r;

  // Next occupancy from the accepted operations.
  always_comb begin
    count_next_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CW'(1'b1);
      2'b01:   count_next_s = count_r - CW'(1'b1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[w_ptr_r] <= bus.wr_data;
    end
  end

  // Pointers, count, registered flags and read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_r        <= {AW{1'b0}};
      r_ptr_r        <= {AW{1'b0}};
      count_r        <= {CW{1'b0}};
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      rd_data_r      <= {DWIDTH{1'b0}};
      rd_valid_r     <= 1'b0;
    end else begin
      count_r        <= count_next_s;
      full_r         <= (count_next_s == CNT_FULL);
      empty_r        <= (count_next_s == {CW{1'b0}});
      almost_full_r  <= (count_next_s >= CNT_AF);
      almost_empty_r <= (count_next_s <= CNT_AE);
      rd_valid_r     <= rd_acc_s;
      if (wr_acc_s) begin
        w_ptr_r <= ptr_inc(w_ptr_r);
      end
      if (rd_acc_s) begin
        r_ptr_r   <= ptr_inc(r_ptr_r);
        rd_data_r <= mem_r[r_ptr_r];
      end
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error capture, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.wr & full_r & ~bus.rd) begin
        overflow_r <= 1'b1;
      end
      if (bus.rd & empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.rd_data      = rd_data_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.count        = count_r;
endmodule
